// File: rtl/spi_mux_sched_pkg.sv
// Shared definitions for the SPI mux owner scheduler.
// State encodings, device count and the one-hot request check.
package spi_mux_sched_pkg;

  localparam int N_DEV = 8;

  typedef enum logic [1:0] {
    ST_MCU  = 2'd0,
    ST_GIN  = 2'd1,
    ST_INT  = 2'd2,
    ST_GOUT = 2'd3
  } state_e;

  function automatic logic is_onehot(
    input logic [N_DEV-1:0] v
  );
    return $onehot(v);
  endfunction

endpackage

// File: rtl/spi_mux_sched_sync_2ff.sv
// Two-flop synchronizer for an asynchronous level input.
// Reset value is a parameter so idle-high strobes stay idle.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ff_q <= {2{RST_VAL}};
    end else begin
      ff_q <= {ff_q[0], d_i};
    end
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/spi_mux_sched.sv
// Owner scheduler for the shared SPI mux: MCU vs internal master,
// with dead-time guards around every handover and a watchdog.
module spi_mux_sched
  import spi_mux_sched_pkg::*;
#(
  parameter int GUARD_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cs2,
  input  logic [N_DEV-1:0] mcu_spi_mux,
  input  logic             int_req,
  input  logic [N_DEV-1:0] int_dev,
  input  logic             int_done,
  input  logic             err_clr,
  output logic [N_DEV-1:0] spi_mux_sel,
  output logic             owner,
  output logic             int_gnt,
  output logic             busy,
  output logic             err_collision,
  output logic             err_timeout,
  output logic             err_badreq
);

  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GW-1:0] G_LAST = GW'(GUARD_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e           state_q;
  logic [GW-1:0]    gcnt_q;
  logic [TW-1:0]    tcnt_q;
  logic [N_DEV-1:0] dev_q;
  logic [N_DEV-1:0] sel_q;
  logic             own_q;
  logic             gnt_q;
  logic             busy_q;
  logic             hold_q;
  logic             err_col_q, err_col_d;
  logic             err_to_q, err_to_d;
  logic             err_bad_q, err_bad_d;
  logic             cs_n_s;
  logic             req_ok;
  logic             col_set, to_set, bad_set;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_cs_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d_i    (cs2),
    .q_o    (cs_n_s)
  );

  // hold_q keeps the first MCU cycle after a guard from re-granting,
  // so the MCU select is always driven for at least one cycle.
  assign req_ok = (state_q == ST_MCU) && int_req && cs_n_s
                  && is_onehot(int_dev) && !hold_q;

  assign bad_set = (state_q == ST_MCU) && int_req
                   && !is_onehot(int_dev);
  assign col_set = (state_q == ST_INT) && !cs_n_s;
  assign to_set  = (state_q == ST_INT) && !int_done
                   && (tcnt_q == T_LAST);

  assign err_col_d = col_set | (err_col_q & ~err_clr);
  assign err_to_d  = to_set  | (err_to_q  & ~err_clr);
  assign err_bad_d = bad_set | (err_bad_q & ~err_clr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_col_q <= 1'b0;
      err_to_q  <= 1'b0;
      err_bad_q <= 1'b0;
    end else begin
      err_col_q <= err_col_d;
      err_to_q  <= err_to_d;
      err_bad_q <= err_bad_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_MCU;
      gcnt_q  <= '0;
      tcnt_q  <= '0;
      dev_q   <= '0;
      sel_q   <= '0;
      own_q   <= 1'b0;
      gnt_q   <= 1'b0;
      busy_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_MCU: begin
          sel_q  <= mcu_spi_mux;
          hold_q <= 1'b0;
          if (req_ok) begin
            state_q <= ST_GIN;
            gcnt_q  <= '0;
            dev_q   <= int_dev;
            sel_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_GIN: begin
          if (!cs_n_s || !int_req) begin
            state_q <= ST_MCU;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            hold_q  <= 1'b1;
          end else if (gcnt_q == G_LAST) begin
            state_q <= ST_INT;
            tcnt_q  <= '0;
            sel_q   <= dev_q;
            own_q   <= 1'b1;
            gnt_q   <= 1'b1;
          end else if (gcnt_q != '1) begin
            gcnt_q <= gcnt_q + 1'b1;
          end
        end
        ST_INT: begin
          if (int_done || tcnt_q == T_LAST) begin
            state_q <= ST_GOUT;
            gcnt_q  <= '0;
            sel_q   <= '0;
            own_q   <= 1'b0;
            gnt_q   <= 1'b0;
          end else if (tcnt_q != '1) begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        ST_GOUT: begin
          if (gcnt_q == G_LAST) begin
            state_q <= ST_MCU;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            hold_q  <= 1'b1;
          end else if (gcnt_q != '1) begin
            gcnt_q <= gcnt_q + 1'b1;
          end
        end
        default: state_q <= ST_MCU;
      endcase
    end
  end

  assign spi_mux_sel   = sel_q;
  assign owner         = own_q;
  assign int_gnt       = gnt_q;
  assign busy          = busy_q;
  assign err_collision = err_col_q;
  assign err_timeout   = err_to_q;
  assign err_badreq    = err_bad_q;

endmodule
